// File: rtl/div16_seq_ctrl.sv
// Sequential 16-bit unsigned restoring divider controller.
// Every subtraction and compare is done by an external add/sub comparator, driven through the add_* ports.
//
// state  | meaning
// S_IDLE | waiting for start; results held
// S_RUN  | 16 shift/subtract iterations, one per cycle
// S_DONE | one-cycle done pulse; results valid
module div16_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_neg,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_r, r_r, d_r;
  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             last;
  logic [WIDTH-1:0] q_step, r_step;

  // R[15] set means the shifted remainder is 17 bits wide, so it always exceeds D
  always_comb begin
    add_a   = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
    add_b   = d_r;
    add_neg = (state == S_RUN);
    take    = r_r[WIDTH-1] | add_cout;
    q_step  = {q_r[WIDTH-2:0], take};
    r_step  = take ? add_sum : add_a;
    last    = (cnt == CNT_W'(WIDTH-1));
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (divisor != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      q_r       <= '0;
      r_r       <= '0;
      d_r       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              q_r      <= dividend;
              r_r      <= '0;
              d_r      <= divisor;
              cnt      <= '0;
              div_zero <= 1'b0;
            end else begin
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          q_r <= q_step;
          r_r <= r_step;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            quotient  <= q_step;
            remainder <= r_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div16_seq_ctrl.sv
// Bench for div16_seq_ctrl: behavioural comparator on add_*, vector table plus random sweep,
// expected results queued at start and popped when done is observed.
module tb_div16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_zero, add_neg, add_cout;
  logic [15:0] quotient, remainder, add_a, add_b, add_sum;

  div16_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero),
    .add_a(add_a), .add_b(add_b), .add_neg(add_neg), .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // comparator: A + ~B + 1 when neg, else A + B; carry out is Cout
  logic [16:0] cmp_full;
  assign cmp_full = add_neg ? ({1'b0, add_a} + {1'b0, ~add_b} + 17'd1)
                            : ({1'b0, add_a} + {1'b0, add_b});
  assign add_sum  = cmp_full[15:0];
  assign add_cout = cmp_full[16];

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          poke;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        chk("done_width", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient", {16'd0, quotient}, {16'd0, e.q});
          chk("remainder", {16'd0, remainder}, {16'd0, e.r});
          chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        end
      end
      prev_done = rst_n & done;
    end
  endtask

  // Drive one request in the next cycle; optional second start pulse at cycle 'poke' of RUN.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                       input logic [15:0] er, input logic edz, input int poke);
    int lat, busy_cnt, neg_cnt, exp_lat;
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = eq; e.r = er; e.dz = edz;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_cnt = 0; neg_cnt = 0;
    exp_lat = edz ? 1 : 17;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == poke) begin
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (add_neg) neg_cnt++;
      if (done) break;
    end
    start = 1'b0;
    chk($sformatf("latency %0h/%0h", a, b), lat, exp_lat);
    chk($sformatf("busy_cycles %0h/%0h", a, b), busy_cnt, exp_lat - 1);
    chk($sformatf("add_neg_cycles %0h/%0h", a, b), neg_cnt, exp_lat - 1);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0: v = 16'h0000;
      1: v = 16'h0001;
      2: v = 16'h8000;
      3: v = 16'hFFFF;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic [15:0] ra, rb;
    vecs[0]  = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0, -1};
    vecs[1]  = '{16'hFFFF,  16'h8001,  16'd1,     16'h7FFE,  1'b0, -1};
    vecs[2]  = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0, -1};
    vecs[3]  = '{16'd5,     16'd9,     16'd0,     16'd5,     1'b0, -1};
    vecs[4]  = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1'b1, -1};
    vecs[5]  = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 5};
    vecs[6]  = '{16'd10,    16'd0,     16'hFFFF,  16'd10,    1'b1, -1};
    vecs[7]  = '{16'd0,     16'd1,     16'd0,     16'd0,     1'b0, -1};
    vecs[8]  = '{16'h8000,  16'h8000,  16'd1,     16'd0,     1'b0, -1};
    vecs[9]  = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0, -1};
    vecs[10] = '{16'd7,     16'h8000,  16'd0,     16'd7,     1'b0, -1};
    vecs[11] = '{16'd1000,  16'd3,     16'd333,   16'd1,     1'b0, -1};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_add_a", {16'd0, add_a}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].poke);

    // reset in the middle of an operation: outputs clear at once, no done follows
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", {16'd0, quotient}, 32'd0);
    chk("abort_remainder", {16'd0, remainder}, 32'd0);
    chk("abort_div_zero", {31'd0, div_zero}, 32'd0);
    chk("abort_add", {add_a, add_b}, 32'd0);
    chk("abort_add_neg", {31'd0, add_neg}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", sb.size(), 0);
    do_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, -1);

    for (int i = 0; i < 2000; i++) begin
      ra = pick();
      rb = pick();
      if (rb == 16'd0) do_op(ra, rb, 16'hFFFF, ra, 1'b1, -1);
      else             do_op(ra, rb, ra / rb, ra % rb, 1'b0, -1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
